// File: rtl/simon_decrypt_core.sv
// simon_decrypt_core
//   Iterative SIMON 32/64 decryption engine. A 64-bit master key is expanded
//   into 32 round keys (one per clock), held in a local buffer, and applied in
//   reverse order to each ciphertext at one round per clock.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   key_valid/key_ready master key handshake; key_in = {k3,k2,k1,k0}
//   ct_valid/ct_ready   ciphertext handshake; ct_in = {x,y}
//   pt_valid/pt_ready   plaintext handshake;  pt_out = {x,y}
//   busy                high while expanding keys or decrypting
module simon_decrypt_core #(
  parameter int unsigned n = 16,
  parameter int unsigned T = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [4*n-1:0] key_in,
  output logic           key_ready,
  input  logic           ct_valid,
  input  logic [2*n-1:0] ct_in,
  output logic           ct_ready,
  output logic           pt_valid,
  output logic [2*n-1:0] pt_out,
  input  logic           pt_ready,
  output logic           busy
);

  localparam int unsigned CW = $clog2(T);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXPAND  = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_DECRYPT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // z0 sequence; character 0 (leftmost) sits in bit 61.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  localparam logic [CW-1:0] LAST_EXP = CW'(T - 5);
  localparam logic [CW-1:0] FIRST_RD = CW'(T - 1);

  function automatic logic [n-1:0] rol(input logic [n-1:0] v, input int unsigned s);
    return (v << s) | (v >> (n - s));
  endfunction

  function automatic logic [n-1:0] ror(input logic [n-1:0] v, input int unsigned s);
    return (v >> s) | (v << (n - s));
  endfunction

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_x;
  logic [n-1:0]  r_y;
  logic [2*n-1:0] r_pt;
  logic [n-1:0]  r_k [0:T-1];

  logic          w_key_hs;
  logic          w_ct_hs;
  logic          w_z;
  logic [n-1:0]  w_tmp;
  logic [n-1:0]  w_newk;
  logic [n-1:0]  w_f;
  logic [n-1:0]  w_ny;

  always_comb begin
    key_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
    // A key offered in the same cycle as a ciphertext wins.
    ct_ready  = (r_state == ST_READY) && !key_valid;
    pt_valid  = (r_state == ST_DONE);
    busy      = (r_state == ST_EXPAND) || (r_state == ST_DECRYPT);
    pt_out    = r_pt;
  end

  assign w_key_hs = key_valid & key_ready;
  assign w_ct_hs  = ct_valid & ct_ready;

  // Key schedule step: r_cnt is the round-key index i during EXPAND.
  assign w_z    = Z0[6'd61 - 6'(r_cnt)];
  assign w_tmp  = ror(r_k[r_cnt + CW'(3)], 3) ^ r_k[r_cnt + CW'(1)];
  assign w_newk = ~r_k[r_cnt] ^ w_tmp ^ ror(w_tmp, 1) ^ {{(n-1){1'b0}}, w_z} ^ n'(3);

  // Inverse round: r_cnt is the round index r during DECRYPT.
  assign w_f  = (rol(r_y, 1) & rol(r_y, 8)) ^ rol(r_y, 2);
  assign w_ny = r_x ^ w_f ^ r_k[r_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_hs) begin
            r_state <= ST_EXPAND;
            r_cnt   <= '0;
          end
        end
        ST_EXPAND: begin
          if (r_cnt == LAST_EXP) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (w_key_hs) begin
            r_state <= ST_EXPAND;
            r_cnt   <= '0;
          end else if (w_ct_hs) begin
            r_x     <= ct_in[2*n-1:n];
            r_y     <= ct_in[n-1:0];
            r_cnt   <= FIRST_RD;
            r_state <= ST_DECRYPT;
          end
        end
        ST_DECRYPT: begin
          r_x   <= r_y;
          r_y   <= w_ny;
          r_cnt <= r_cnt - 1'b1;
          // Working registers are separate from pt_out so the output only
          // moves on the final round, and is registered with pt_valid.
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_pt    <= {r_y, w_ny};
          end
        end
        ST_DONE: begin
          if (pt_ready) r_state <= ST_READY;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Round-key buffer: no reset, contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (w_key_hs) begin
      r_k[0] <= key_in[n-1:0];
      r_k[1] <= key_in[2*n-1:n];
      r_k[2] <= key_in[3*n-1:2*n];
      r_k[3] <= key_in[4*n-1:3*n];
    end else if (r_state == ST_EXPAND) begin
      r_k[r_cnt + CW'(4)] <= w_newk;
    end
  end

endmodule

// File: tb/tb_simon_decrypt_core.sv
// tb_simon_decrypt_core
//   Directed bench for simon_decrypt_core with a forward-direction SIMON 32/64
//   reference used to generate ciphertexts for random plaintexts.
module tb_simon_decrypt_core;

  localparam logic [63:0] KNOWN_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KNOWN_CT  = 32'hc69b_e9bb;
  localparam logic [31:0] KNOWN_PT  = 32'h6565_6877;
  localparam logic [61:0] ZSEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [63:0] key_in;
  logic        key_ready;
  logic        ct_valid;
  logic [31:0] ct_in;
  logic        ct_ready;
  logic        pt_valid;
  logic [31:0] pt_out;
  logic        pt_ready;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  simon_decrypt_core #(.n(16), .T(32)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .ct_valid(ct_valid), .ct_in(ct_in), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt_out(pt_out), .pt_ready(pt_ready),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Forward SIMON 32/64 encryption.
  function automatic logic [31:0] simon_enc(input logic [63:0] key, input logic [31:0] pt);
    logic [15:0] k [0:31];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      t = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'b0, ZSEQ[61-(i-4)]} ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]}) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic load_key(input logic [63:0] k);
    int cnt;
    cnt = 0;
    while (!key_ready && cnt < 100) begin tick(); cnt++; end
    check("key_ready_wait", 64'(cnt < 100), 64'd1);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    check("expand_wait", 64'(cnt < 100), 64'd1);
  endtask

  task automatic run_ct(input logic [31:0] ct, input logic [31:0] exp, input int stall);
    int cnt;
    cnt = 0;
    while (!ct_ready && cnt < 100) begin tick(); cnt++; end
    check("ct_ready_wait", 64'(cnt < 100), 64'd1);
    ct_valid = 1'b1;
    ct_in    = ct;
    tick();
    ct_valid = 1'b0;
    cnt = 0;
    while (!pt_valid && cnt < 100) begin tick(); cnt++; end
    check("pt_valid_wait", 64'(cnt < 100), 64'd1);
    check("pt_out", 64'(pt_out), 64'(exp));
    for (int s = 0; s < stall; s++) tick();
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    bit bad;
    logic [63:0] k2;
    logic [31:0] pt;

    rst = 1'b1; key_valid = 1'b0; key_in = '0;
    ct_valid = 1'b0; ct_in = '0; pt_ready = 1'b0;
    tick();
    tick();
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_ct_ready",  64'(ct_ready),  64'd0);
    check("rst_pt_valid",  64'(pt_valid),  64'd0);
    check("rst_pt_out",    64'(pt_out),    64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;

    // Ciphertext offered early: ignored in IDLE and through EXPAND.
    ct_valid = 1'b1;
    ct_in    = KNOWN_CT;
    tick();
    check("idle_ct_ready", 64'(ct_ready), 64'd0);
    key_valid = 1'b1;
    key_in    = KNOWN_KEY;
    tick();
    key_valid = 1'b0;
    check("expand_busy", 64'(busy), 64'd1);
    cnt = 0;
    bad = 1'b0;
    while (busy && cnt < 100) begin
      if (ct_ready || pt_valid) bad = 1'b1;
      tick();
      cnt++;
    end
    check("expand_cycles", 64'(cnt), 64'd28);
    check("expand_no_accept", 64'(bad), 64'd0);
    check("first_ready_ct_ready", 64'(ct_ready), 64'd1);
    tick();
    ct_valid = 1'b0;
    check("decrypt_busy", 64'(busy), 64'd1);
    cnt = 0;
    while (!pt_valid && cnt < 100) begin tick(); cnt++; end
    check("decrypt_latency", 64'(cnt), 64'd32);
    check("known_pt", 64'(pt_out), 64'(KNOWN_PT));

    // Stalled consumer holds output and blocks both inputs.
    key_valid = 1'b1;
    ct_valid  = 1'b1;
    bad = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
      if (!pt_valid || pt_out !== KNOWN_PT || ct_ready || key_ready) bad = 1'b1;
    end
    check("stall_hold", 64'(bad), 64'd0);
    key_valid = 1'b0;
    ct_valid  = 1'b0;
    pt_ready  = 1'b1;
    tick();
    pt_ready  = 1'b0;
    check("release_pt_valid",  64'(pt_valid),  64'd0);
    check("release_key_ready", 64'(key_ready), 64'd1);
    check("release_ct_ready",  64'(ct_ready),  64'd1);
    check("release_busy",      64'(busy),      64'd0);
    check("release_pt_out",    64'(pt_out),    64'(KNOWN_PT));

    // Key and ciphertext together: key wins.
    k2 = {$urandom, $urandom};
    key_valid = 1'b1;
    key_in    = k2;
    ct_valid  = 1'b1;
    ct_in     = KNOWN_CT;
    #1;
    check("prio_ct_ready",  64'(ct_ready),  64'd0);
    check("prio_key_ready", 64'(key_ready), 64'd1);
    tick();
    key_valid = 1'b0;
    ct_valid  = 1'b0;
    check("prio_expand", 64'(busy), 64'd1);
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    check("prio_expand_cycles", 64'(cnt), 64'd28);
    for (int i = 0; i < 100; i++) begin
      pt = $urandom;
      run_ct(simon_enc(k2, pt), pt, 0);
    end

    // Reset in the middle of decryption.
    ct_valid = 1'b1;
    ct_in    = simon_enc(k2, 32'h1234_5678);
    cnt = 0;
    while (!ct_ready && cnt < 100) begin tick(); cnt++; end
    tick();
    ct_valid = 1'b0;
    for (int s = 0; s < 16; s++) tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_pt_valid",  64'(pt_valid),  64'd0);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_ct_ready",  64'(ct_ready),  64'd0);
    check("abort_key_ready", 64'(key_ready), 64'd1);
    ct_valid = 1'b1;
    bad = 1'b0;
    for (int s = 0; s < 40; s++) begin
      tick();
      if (pt_valid || ct_ready || busy) bad = 1'b1;
    end
    ct_valid = 1'b0;
    check("abort_no_output", 64'(bad), 64'd0);
    load_key(KNOWN_KEY);
    run_ct(KNOWN_CT, KNOWN_PT, 2);

    // Random keys and plaintexts with consumer stalls.
    for (int kk = 0; kk < 200; kk++) begin
      k2 = {$urandom, $urandom};
      load_key(k2);
      for (int j = 0; j < 5; j++) begin
        pt = $urandom;
        run_ct(simon_enc(k2, pt), pt, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
